// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour type, default resolution, sync levels and
// the dashed centre-net geometry used by the optional centre line.
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    localparam int     H_RES_DEFAULT = 640;
    localparam int     V_RES_DEFAULT = 480;

    localparam rgb12_t BLACK_RGB     = 12'h000;
    localparam rgb12_t NET_RGB       = 12'hFF0;
    localparam logic   SYNC_INACTIVE = 1'b1;

    // Centre net occupies the columns strictly between these two values
    localparam int     NET_X_LO      = 316;
    localparam int     NET_X_HI      = 324;

    // Zero-extend a 10-bit coordinate so sums and compares cannot wrap
    function automatic logic [10:0] widen(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/vga_ball_gen_ball_axis.sv
// One axis of the ball: position, travel direction and edge bounce.
// Moves by SPEED on each i_step and clamps to [0, LIMIT-SIZE]; o_bounce is a
// combinational pulse in the cycle a step hits an edge.
module ball_axis
    import vga_pkg::*;
#(
    parameter int LIMIT     = 640,
    parameter int SIZE      = 8,
    parameter int SPEED     = 2,
    parameter int RESET_POS = 316
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    output logic [9:0] o_pos,
    output logic       o_bounce
);

    localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
    localparam logic [10:0] STEP    = 11'(SPEED);
    localparam logic [9:0]  RST_POS = 10'(RESET_POS);

    logic [9:0]  r_pos;
    dir_t        r_dir;
    logic [10:0] w_fwd;
    logic [9:0]  w_pos_next;
    dir_t        w_dir_next;
    logic        w_bounce;

    // Next position/direction: advance, or clamp to the edge and reverse
    always_comb begin
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        w_bounce   = 1'b0;
        w_fwd      = widen(r_pos) + STEP;
        if (i_step) begin
            if (r_dir == DIR_POS) begin
                if (w_fwd >= MAX_POS) begin
                    w_pos_next = MAX_POS[9:0];
                    w_dir_next = DIR_NEG;
                    w_bounce   = 1'b1;
                end else begin
                    w_pos_next = w_fwd[9:0];
                end
            end else begin
                if (widen(r_pos) <= STEP) begin
                    w_pos_next = 10'd0;
                    w_dir_next = DIR_POS;
                    w_bounce   = 1'b1;
                end else begin
                    w_pos_next = r_pos - STEP[9:0];
                end
            end
        end
    end

    // Position and direction registers, centred and heading positive at reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos <= RST_POS;
            r_dir <= DIR_POS;
        end else begin
            r_pos <= w_pos_next;
            r_dir <= w_dir_next;
        end
    end

    assign o_pos    = r_pos;
    assign o_bounce = w_bounce;

endmodule

// File: rtl/vga_ball_gen.sv
// Bouncing-ball pixel generator sitting between the VGA timing generator and
// the pins. Two-stage pipeline: S1 registers the hit test and syncs, S2
// registers the colour and syncs again, so colour and syncs stay aligned.
// Optional macro VGA_BALL_CENTRE_LINE_EN draws a dashed yellow centre net
// on background pixels; the ball is drawn over it.
module vga_ball_gen
    import vga_pkg::*;
#(
    parameter int     H_RES        = H_RES_DEFAULT,
    parameter int     V_RES        = V_RES_DEFAULT,
    parameter int     BALL_SIZE    = 8,
    parameter int     SPEED        = 2,
    parameter int     FLASH_FRAMES = 8,
    parameter rgb12_t BALL_RGB     = 12'hFFF,
    parameter rgb12_t FLASH_RGB    = 12'hF00,
    parameter rgb12_t BG_RGB       = 12'h00F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        visible,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int          FW         = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic [10:0] SIZE11     = 11'(BALL_SIZE);

    logic          w_step;
    logic [9:0]    w_ball_x;
    logic [9:0]    w_ball_y;
    logic          w_bounce_x;
    logic          w_bounce_y;
    logic [10:0]   w_px;
    logic [10:0]   w_py;
    logic [10:0]   w_bx;
    logic [10:0]   w_by;
    logic          w_hit;
    logic          w_net;
    rgb12_t        w_rgb_next;

    logic [FW-1:0] r_flash;
    logic          r_hit_s1;
    logic          r_vis_s1;
    logic          r_net_s1;
    logic          r_hs_s1;
    logic          r_vs_s1;
    rgb12_t        r_rgb;
    logic          r_hs_s2;
    logic          r_vs_s2;

    // Motion only happens on a frame tick, which falls in vertical blanking
    assign w_step = frame_tick & ~pause;

    ball_axis #(
        .LIMIT     (H_RES),
        .SIZE      (BALL_SIZE),
        .SPEED     (SPEED),
        .RESET_POS ((H_RES - BALL_SIZE) / 2)
    ) u_axis_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_step   (w_step),
        .o_pos    (w_ball_x),
        .o_bounce (w_bounce_x)
    );

    ball_axis #(
        .LIMIT     (V_RES),
        .SIZE      (BALL_SIZE),
        .SPEED     (SPEED),
        .RESET_POS ((V_RES - BALL_SIZE) / 2)
    ) u_axis_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_step   (w_step),
        .o_pos    (w_ball_y),
        .o_bounce (w_bounce_y)
    );

    // Flash counter: reload on any bounce, else count frames down to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flash <= '0;
        end else if (frame_tick) begin
            if (w_bounce_x | w_bounce_y) begin
                r_flash <= FLASH_LOAD;
            end else if (r_flash != '0) begin
                r_flash <= r_flash - FW'(1);
            end
        end
    end

    assign w_px  = widen(pix_x);
    assign w_py  = widen(pix_y);
    assign w_bx  = widen(w_ball_x);
    assign w_by  = widen(w_ball_y);
    assign w_hit = visible
                 && (w_px >= w_bx) && (w_px < w_bx + SIZE11)
                 && (w_py >= w_by) && (w_py < w_by + SIZE11);

`ifdef VGA_BALL_CENTRE_LINE_EN
    assign w_net = (w_px > 11'(NET_X_LO)) && (w_px < 11'(NET_X_HI)) && !pix_y[4];
`else
    assign w_net = 1'b0;
`endif

    // Stage 1: capture hit test, visibility, net flag and raw syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_s1 <= 1'b0;
            r_vis_s1 <= 1'b0;
            r_net_s1 <= 1'b0;
            r_hs_s1  <= SYNC_INACTIVE;
            r_vs_s1  <= SYNC_INACTIVE;
        end else begin
            r_hit_s1 <= w_hit;
            r_vis_s1 <= visible;
            r_net_s1 <= w_net;
            r_hs_s1  <= hsync_in;
            r_vs_s1  <= vsync_in;
        end
    end

    // Colour select: blank outside the visible area, ball over net over background
    always_comb begin
        w_rgb_next = BLACK_RGB;
        if (r_vis_s1) begin
            if (r_hit_s1) begin
                w_rgb_next = (r_flash != '0) ? FLASH_RGB : BALL_RGB;
            end else if (r_net_s1) begin
                w_rgb_next = NET_RGB;
            end else begin
                w_rgb_next = BG_RGB;
            end
        end
    end

    // Stage 2: register colour and the already-delayed syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb   <= BLACK_RGB;
            r_hs_s2 <= SYNC_INACTIVE;
            r_vs_s2 <= SYNC_INACTIVE;
        end else begin
            r_rgb   <= w_rgb_next;
            r_hs_s2 <= r_hs_s1;
            r_vs_s2 <= r_vs_s1;
        end
    end

    assign rgb       = r_rgb;
    assign hsync_out = r_hs_s2;
    assign vsync_out = r_vs_s2;

endmodule

// File: tb/tb_vga_ball_gen.sv
// Testbench for vga_ball_gen. Runs a default 640x480 instance and a square
// 480x480 instance (whose ball reaches a corner) side by side against an
// arithmetic model of ball motion, flash timing and pixel colour.
module tb_vga_ball_gen;

    localparam int SIZE  = 8;
    localparam int SPD   = 2;
    localparam int FLASH = 8;

    typedef struct {
        int          d;
        int          x;
        int          y;
        logic [11:0] got;
        logic [11:0] exp;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        visible;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_tick;
    logic        pause;
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic        hs_a;
    logic        vs_a;
    logic        hs_b;
    logic        vs_b;

    int tests_run    = 0;
    int tests_failed = 0;

    int mx[2];
    int my[2];
    int mdx[2];
    int mdy[2];
    int mflash[2];
    int resH[2];
    int resV[2];

    sample_t scanQ[$];

    always #5 clk = ~clk;

    vga_ball_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .visible    (visible),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick),
        .pause      (pause),
        .rgb        (rgb_a),
        .hsync_out  (hs_a),
        .vsync_out  (vs_a)
    );

    vga_ball_gen #(
        .H_RES (480),
        .V_RES (480)
    ) dut_sq (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .visible    (visible),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick),
        .pause      (pause),
        .rgb        (rgb_b),
        .hsync_out  (hs_b),
        .vsync_out  (vs_b)
    );

    // Expected colour of one pixel from the modelled ball of instance d
    function automatic logic [11:0] model_rgb(input int d, input int x, input int y, input bit vis);
        bit hit;
        if (!vis) return 12'h000;
        hit = (x >= mx[d]) && (x < mx[d] + SIZE) && (y >= my[d]) && (y < my[d] + SIZE);
        if (hit) return (mflash[d] != 0) ? 12'hF00 : 12'hFFF;
`ifdef VGA_BALL_CENTRE_LINE_EN
        if (x > 316 && x < 324 && ((y / 16) % 2) == 0) return 12'hFF0;
`endif
        return 12'h00F;
    endfunction

    // Reset model: ball centred on each screen, moving right and down
    task automatic model_reset();
        resH[0] = 640; resV[0] = 480;
        resH[1] = 480; resV[1] = 480;
        for (int d = 0; d < 2; d++) begin
            mx[d]     = (resH[d] - SIZE) / 2;
            my[d]     = (resV[d] - SIZE) / 2;
            mdx[d]    = 1;
            mdy[d]    = 1;
            mflash[d] = 0;
        end
    endtask

    // One axis of motion: step, or clamp to the wall and turn around
    task automatic moveAxis(inout int pos, inout int dir, input int limit, inout bit bounced);
        if (dir > 0) begin
            if (pos + SPD >= limit - SIZE) begin
                pos = limit - SIZE; dir = -1; bounced = 1'b1;
            end else begin
                pos = pos + SPD;
            end
        end else begin
            if (pos <= SPD) begin
                pos = 0; dir = 1; bounced = 1'b1;
            end else begin
                pos = pos - SPD;
            end
        end
    endtask

    task automatic model_tick(input bit paused);
        bit b;
        for (int d = 0; d < 2; d++) begin
            b = 1'b0;
            if (!paused) begin
                moveAxis(mx[d], mdx[d], resH[d], b);
                moveAxis(my[d], mdy[d], resV[d], b);
            end
            if (b) mflash[d] = FLASH;
            else if (mflash[d] > 0) mflash[d] = mflash[d] - 1;
        end
    endtask

    // One-cycle frame_tick, applied to both DUTs and the model
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(pause);
    endtask

    // Present one pixel and collect both colours two cycles later
    task automatic applyStimulus(input int x, input int y, input bit vis,
                                 output logic [11:0] gotA, output logic [11:0] gotB);
        @(negedge clk);
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        visible = vis;
        @(negedge clk);
        @(negedge clk);
        gotA = rgb_a;
        gotB = rgb_b;
    endtask

    // Sample the edges of both modelled balls into scanQ with expectations
    task automatic scan_ball();
        int px[$];
        int py[$];
        logic [11:0] a;
        logic [11:0] b;
        scanQ.delete();
        px.push_back(mx[0]);            py.push_back(my[0]);
        px.push_back(mx[0] + SIZE - 1); py.push_back(my[0] + SIZE - 1);
        px.push_back(mx[0] + SIZE);     py.push_back(my[0]);
        px.push_back(mx[0]);            py.push_back(my[0] + SIZE);
        if (mx[0] > 0) begin px.push_back(mx[0] - 1); py.push_back(my[0]); end
        if (my[0] > 0) begin px.push_back(mx[0]); py.push_back(my[0] - 1); end
        px.push_back(mx[1]);            py.push_back(my[1]);
        px.push_back(mx[1] + SIZE);     py.push_back(my[1] + SIZE - 1);
        foreach (px[i]) begin
            applyStimulus(px[i], py[i], 1'b1, a, b);
            scanQ.push_back('{0, px[i], py[i], a, model_rgb(0, px[i], py[i], 1'b1)});
            scanQ.push_back('{1, px[i], py[i], b, model_rgb(1, px[i], py[i], 1'b1)});
        end
    endtask

    task automatic test_reset();
        logic [11:0] a;
        logic [11:0] b;
        rst_n = 1'b0; pix_x = 10'd316; pix_y = 10'd236; visible = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rgb_a !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_rgb: got %h expected 000", rgb_a); end
        tests_run++;
        if (rgb_b !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_rgb_sq: got %h expected 000", rgb_b); end
        tests_run++;
        if ({hs_a, vs_a} !== 2'b11) begin tests_failed++; $display("[TB] FAIL reset_sync: got %b expected 11", {hs_a, vs_a}); end
        tests_run++;
        if ({hs_b, vs_b} !== 2'b11) begin tests_failed++; $display("[TB] FAIL reset_sync_sq: got %b expected 11", {hs_b, vs_b}); end
        @(negedge clk);
        rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        model_reset();
        applyStimulus(316, 236, 1'b1, a, b);
        tests_run++;
        if (a !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL ball_centre: got %h expected FFF", a); end
        applyStimulus(0, 0, 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL background_origin: got %h expected 00F", a); end
        applyStimulus(318, 238, 1'b0, a, b);
        tests_run++;
        if (a !== 12'h000) begin tests_failed++; $display("[TB] FAIL invisible_ball: got %h expected 000", a); end
    endtask

    task automatic test_sync();
        bit hq[$];
        bit vq[$];
        bit eh;
        bit ev;
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        hq = '{1'b1, 1'b1};
        vq = '{1'b1, 1'b1};
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            eh = hq.pop_front();
            ev = vq.pop_front();
            tests_run++;
            if (hs_a !== eh || hs_b !== eh) begin
                tests_failed++; $display("[TB] FAIL hsync_delay k=%0d: got %b/%b expected %b", k, hs_a, hs_b, eh);
            end
            tests_run++;
            if (vs_a !== ev || vs_b !== ev) begin
                tests_failed++; $display("[TB] FAIL vsync_delay k=%0d: got %b/%b expected %b", k, vs_a, vs_b, ev);
            end
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
            hq.push_back(hsync_in);
            vq.push_back(vsync_in);
        end
        @(negedge clk);
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_bounce_right();
        logic [11:0] a;
        logic [11:0] b;
        for (int t = 1; t <= 168; t++) begin
            do_tick();
            scan_ball();
            foreach (scanQ[i]) begin
                tests_run++;
                if (scanQ[i].got !== scanQ[i].exp) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_right t=%0d dut%0d pix(%0d,%0d): got %h expected %h",
                             t, scanQ[i].d, scanQ[i].x, scanQ[i].y, scanQ[i].got, scanQ[i].exp);
                end
            end
            if (t == 118) begin
                applyStimulus(472, 472, 1'b1, a, b);
                tests_run++;
                if (b !== 12'hF00) begin tests_failed++; $display("[TB] FAIL corner_flash: got %h expected F00", b); end
                applyStimulus(479, 479, 1'b1, a, b);
                tests_run++;
                if (b !== 12'hF00) begin tests_failed++; $display("[TB] FAIL corner_far_pixel: got %h expected F00", b); end
            end
            if (t == 125) begin
                applyStimulus(mx[1], my[1], 1'b1, a, b);
                tests_run++;
                if (b !== 12'hF00) begin tests_failed++; $display("[TB] FAIL corner_flash_last: got %h expected F00", b); end
            end
            if (t == 126) begin
                applyStimulus(mx[1], my[1], 1'b1, a, b);
                tests_run++;
                if (b !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL corner_flash_end: got %h expected FFF", b); end
            end
            if (t == 158) begin
                applyStimulus(632, my[0], 1'b1, a, b);
                tests_run++;
                if (a !== 12'hF00) begin tests_failed++; $display("[TB] FAIL right_wall_flash: got %h expected F00", a); end
                applyStimulus(631, my[0], 1'b1, a, b);
                tests_run++;
                if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL right_wall_left_edge: got %h expected 00F", a); end
            end
            if (t == 166) begin
                applyStimulus(mx[0], my[0], 1'b1, a, b);
                tests_run++;
                if (a !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL right_flash_end: got %h expected FFF", a); end
            end
        end
    endtask

    task automatic test_bounce_left();
        logic [11:0] a;
        logic [11:0] b;
        int budget;
        budget = 400;
        while (!(mx[0] == 0 && mdx[0] == 1) && budget > 0) begin
            budget--;
            do_tick();
            scan_ball();
            foreach (scanQ[i]) begin
                tests_run++;
                if (scanQ[i].got !== scanQ[i].exp) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_left dut%0d pix(%0d,%0d): got %h expected %h",
                             scanQ[i].d, scanQ[i].x, scanQ[i].y, scanQ[i].got, scanQ[i].exp);
                end
            end
        end
        tests_run++;
        if (budget == 0) begin tests_failed++; $display("[TB] FAIL left_wall_budget: got no bounce expected bounce"); end
        applyStimulus(0, my[0], 1'b1, a, b);
        tests_run++;
        if (a !== 12'hF00) begin tests_failed++; $display("[TB] FAIL left_wall_flash: got %h expected F00", a); end
        do_tick();
        applyStimulus(1, my[0], 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL left_rebound_gap: got %h expected 00F", a); end
        applyStimulus(2, my[0], 1'b1, a, b);
        tests_run++;
        if (a !== 12'hF00) begin tests_failed++; $display("[TB] FAIL left_rebound_pos: got %h expected F00", a); end
    endtask

    task automatic test_pause();
        logic [11:0] a;
        logic [11:0] b;
        int sx;
        int sy;
        sx = mx[0];
        sy = my[0];
        pause = 1'b1;
        for (int t = 0; t < 10; t++) begin
            do_tick();
            scan_ball();
            foreach (scanQ[i]) begin
                tests_run++;
                if (scanQ[i].got !== scanQ[i].exp) begin
                    tests_failed++;
                    $display("[TB] FAIL paused t=%0d dut%0d pix(%0d,%0d): got %h expected %h",
                             t, scanQ[i].d, scanQ[i].x, scanQ[i].y, scanQ[i].got, scanQ[i].exp);
                end
            end
        end
        applyStimulus(sx, sy, 1'b1, a, b);
        tests_run++;
        if (a !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL pause_hold: got %h expected FFF", a); end
        applyStimulus(sx + SIZE, sy, 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL pause_edge: got %h expected 00F", a); end
        pause = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [11:0] b;
        int x;
        int y;
        bit v;
        for (int it = 0; it < 80; it++) begin
            pause = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_tick();
            for (int p = 0; p < 4; p++) begin
                x = mx[p % 2] + $urandom_range(0, 11) - 2;
                y = my[p % 2] + $urandom_range(0, 11) - 2;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (p == 3) begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
                v = ($urandom_range(0, 4) != 0);
                applyStimulus(x, y, v, a, b);
                tests_run++;
                if (a !== model_rgb(0, x, y, v)) begin
                    tests_failed++;
                    $display("[TB] FAIL random dut0 pix(%0d,%0d) vis=%0b: got %h expected %h", x, y, v, a, model_rgb(0, x, y, v));
                end
                tests_run++;
                if (b !== model_rgb(1, x, y, v)) begin
                    tests_failed++;
                    $display("[TB] FAIL random dut1 pix(%0d,%0d) vis=%0b: got %h expected %h", x, y, v, b, model_rgb(1, x, y, v));
                end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [11:0] a;
        logic [11:0] b;
        hsync_in = 1'b0; vsync_in = 1'b0;
        pix_x = 10'(mx[0]); pix_y = 10'(my[0]); visible = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rgb_a !== 12'h000 || rgb_b !== 12'h000) begin
            tests_failed++; $display("[TB] FAIL midframe_reset_rgb: got %h/%h expected 000", rgb_a, rgb_b);
        end
        tests_run++;
        if ({hs_a, vs_a, hs_b, vs_b} !== 4'b1111) begin
            tests_failed++; $display("[TB] FAIL midframe_reset_sync: got %b expected 1111", {hs_a, vs_a, hs_b, vs_b});
        end
        rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        model_reset();
        applyStimulus(316, 236, 1'b1, a, b);
        tests_run++;
        if (a !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL midframe_recentre: got %h expected FFF", a); end
        applyStimulus(236, 236, 1'b1, a, b);
        tests_run++;
        if (b !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL midframe_recentre_sq: got %h expected FFF", b); end
    endtask

    task automatic test_centre_line();
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] expNet;
`ifdef VGA_BALL_CENTRE_LINE_EN
        expNet = 12'hFF0;
`else
        expNet = 12'h00F;
`endif
        applyStimulus(320, 5, 1'b1, a, b);
        tests_run++;
        if (a !== expNet) begin tests_failed++; $display("[TB] FAIL net_dash: got %h expected %h", a, expNet); end
        applyStimulus(320, 20, 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL net_gap: got %h expected 00F", a); end
        applyStimulus(316, 5, 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL net_left_bound: got %h expected 00F", a); end
        applyStimulus(324, 5, 1'b1, a, b);
        tests_run++;
        if (a !== 12'h00F) begin tests_failed++; $display("[TB] FAIL net_right_bound: got %h expected 00F", a); end
        applyStimulus(320, 240, 1'b1, a, b);
        tests_run++;
        if (a !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL net_under_ball: got %h expected FFF", a); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync();
        test_centre_line();
        test_bounce_right();
        test_bounce_left();
        test_pause();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
